key_event_ctrl: RTL



---
 rtl/key_pkg.sv | 19 +
 rtl/key_press_fsm.sv | 128 ++++++++++++
 rtl/key_event_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key event sequencer: event codes, press FSM
// states and the clock-to-millisecond conversion.
package key_pkg;

  localparam logic [1:0] EVT_SHORT  = 2'd0;
  localparam logic [1:0] EVT_LONG   = 2'd1;
  localparam logic [1:0] EVT_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } key_state_e;

  function automatic logic [31:0] ticks_per_ms(input int unsigned freq_mhz);
    return 32'(freq_mhz * 1000);
  endfunction

endpackage

// File: rtl/key_press_fsm.sv
// Per-key press timer: classifies a debounced key into SHORT/LONG/REPEAT
// events and buffers one event for the arbiter, flagging drops.
module key_press_fsm
  import key_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       level,
  input  logic       ms_tick,
  input  logic       grant,
  input  logic       ovf_clr,
  output logic       pend,
  output logic [1:0] pcode,
  output logic       ovf
);

  localparam logic [15:0] LONG_C = 16'(LONG_MS);
  localparam logic [15:0] REP_C  = 16'(REPEAT_MS);

  key_state_e  state;
  logic        key_prev;
  logic [15:0] hcnt;
  logic [15:0] hcnt_inc;
  logic        press;
  logic        rel;
  logic        emit;
  logic        overflow;
  logic [1:0]  code;

  assign press    = key_prev & ~level;
  assign rel      = ~key_prev & level;
  assign hcnt_inc = hcnt + 16'd1;
  assign overflow = emit & pend & ~grant;

  // hcnt restarts at 0 on LONG, so a release seen in HELD is always short.
  always_comb begin
    emit = 1'b0;
    code = EVT_SHORT;
    if (en) begin
      case (state)
        HELD: begin
          if (rel) begin
            emit = 1'b1;
          end else if (ms_tick && hcnt_inc == LONG_C) begin
            emit = 1'b1;
            code = EVT_LONG;
          end
        end
        REPEAT: begin
          if (!rel && ms_tick && hcnt_inc == REP_C) begin
            emit = 1'b1;
            code = EVT_REPEAT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      key_prev <= 1'b1;
      hcnt     <= '0;
    end else begin
      key_prev <= level;
      if (!en) begin
        state <= IDLE;
        hcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press) begin
              state <= HELD;
              hcnt  <= '0;
            end
          end
          HELD: begin
            if (rel) begin
              state <= IDLE;
            end else if (ms_tick) begin
              if (hcnt_inc == LONG_C) begin
                state <= REPEAT;
                hcnt  <= '0;
              end else begin
                hcnt <= hcnt_inc;
              end
            end
          end
          REPEAT: begin
            if (rel) begin
              state <= IDLE;
            end else if (ms_tick) begin
              hcnt <= (hcnt_inc == REP_C) ? '0 : hcnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A grant in the same cycle frees the slot, so the new event is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 1'b0;
      pcode <= EVT_SHORT;
      ovf   <= 1'b0;
    end else begin
      if (emit && !overflow) begin
        pend  <= 1'b1;
        pcode <= code;
      end else if (grant) begin
        pend <= 1'b0;
      end
      if (overflow) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event sequencer: shared ms prescaler, one press FSM per key and a
// round-robin arbiter feeding a registered valid/ready event port.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int  NUM_KEYS  = 4,
  parameter int  FREQ      = 100,
  parameter int  LONG_MS   = 1000,
  parameter int  REPEAT_MS = 200,
  localparam int KW        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] key_level,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KW-1:0]       evt_key,
  output logic [1:0]          evt_code,
  output logic [NUM_KEYS-1:0] ovf_flags,
  input  logic                ovf_clr
);

  localparam logic [31:0] TPM = ticks_per_ms(FREQ);
  localparam int unsigned NK  = NUM_KEYS;

  logic [31:0]         pre_cnt;
  logic                ms_tick;
  logic [NUM_KEYS-1:0] pend;
  logic [NUM_KEYS-1:0] grant;
  logic [1:0]          pcode [NUM_KEYS];
  logic [KW-1:0]       ptr;
  logic [KW-1:0]       gnt_idx;
  logic                gnt_any;
  logic                load;

  assign ms_tick = (pre_cnt == TPM - 32'd1);
  assign load    = ~evt_valid | evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= ms_tick ? '0 : pre_cnt + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_press_fsm #(
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS)
    ) u_fsm (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .level  (key_level[g]),
      .ms_tick(ms_tick),
      .grant  (grant[g]),
      .ovf_clr(ovf_clr),
      .pend   (pend[g]),
      .pcode  (pcode[g]),
      .ovf    (ovf_flags[g])
    );
  end

  // Search starts one past the last grant so every key gets a turn.
  always_comb begin : arb
    int unsigned j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 1; i <= NK; i++) begin
      j = (32'(ptr) + i) % NK;
      if (!gnt_any && pend[j]) begin
        gnt_any = 1'b1;
        gnt_idx = KW'(j);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (load && gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_code  <= EVT_SHORT;
      ptr       <= '0;
    end else if (load) begin
      evt_valid <= gnt_any;
      if (gnt_any) begin
        evt_key  <= gnt_idx;
        evt_code <= pcode[gnt_idx];
        ptr      <= gnt_idx;
      end
    end
  end

endmodule
